// File: rtl/decode_sequencer.sv
// ============================================================================
// Module   : decode_sequencer
// Brief    : Two-entry decode buffer that tags each static instruction with a
//            monotonically increasing dynamic id, carries its fault verdict
//            downstream, and optionally halts intake after a faulting push.
// Config   : DECSEQ_HALT_ON_FAULT_EN - when defined, a faulting push moves the
//            sequencer to HALT until the next flush.
// di_o     : packed as {valid, fault, id[ID_W-1:0], si[SI_W-1:0]}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_sequencer #(
    parameter int SI_W = 32,
    parameter int ID_W = 20
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SI_W-1:0]       si_i,
    input  logic                  si_valid_i,
    output logic                  si_ready_o,
    input  logic                  fault_i,
    output logic [SI_W+ID_W+1:0]  di_o,
    output logic                  di_valid_o,
    input  logic                  di_ready_i,
    input  logic                  flush_i,
    output logic                  halted_o,
    output logic                  busy_o
);

    // One stored entry: {fault, id, si}
    localparam int          c_ENT_W  = SI_W + ID_W + 1;
    localparam logic [ID_W-1:0] c_ID_ONE = {{(ID_W-1){1'b0}}, 1'b1};

    logic [c_ENT_W-1:0] r_mem [2];
    logic               r_head;
    logic [1:0]         r_count;
    logic [ID_W-1:0]    r_id;

    logic               w_push;
    logic               w_pop;
    logic               w_tail;
    logic               w_run;

`ifdef DECSEQ_HALT_ON_FAULT_EN
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;

    assign w_run    = (r_state == ST_RUN);
    assign halted_o = (r_state == ST_HALT);

    // Run/halt control: a faulting push stops intake, only a flush resumes it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_RUN;
        end else if (flush_i) begin
            r_state <= ST_RUN;
        end else if (w_push && fault_i) begin
            r_state <= ST_HALT;
        end
    end
`else
    assign w_run    = 1'b1;
    assign halted_o = 1'b0;
`endif

    // Ready is deliberately independent of di_ready_i so a full buffer never
    // creates a combinational path from downstream back to fetch.
    assign si_ready_o = (r_count < 2'd2) && w_run && !flush_i;
    assign di_valid_o = (r_count != 2'd0);
    assign busy_o     = (r_count != 2'd0);
    assign di_o       = {di_valid_o, r_mem[r_head]};

    assign w_push = si_valid_i && si_ready_o;
    assign w_pop  = di_valid_o && di_ready_i;
    // Tail slot: head when empty, the other slot when one entry is held
    assign w_tail = r_head ^ r_count[0];

    // FIFO storage, pointers and id counter; flush empties but keeps ids
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_id     <= '0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (flush_i) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[w_tail] <= {fault_i, r_id, si_i};
                r_id          <= r_id + c_ID_ONE;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_sequencer.sv
// ============================================================================
// Module   : tb_decode_sequencer
// Brief    : Scoreboard bench for decode_sequencer (small ID_W so id wrap is
//            reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_sequencer;

    localparam int SI_W  = 8;
    localparam int ID_W  = 4;
    localparam int DI_W  = SI_W + ID_W + 2;
    localparam int ENT_W = SI_W + ID_W + 1;

`ifdef DECSEQ_HALT_ON_FAULT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic             clk;
    logic             rstn;
    logic [SI_W-1:0]  si_i;
    logic             si_valid_i;
    logic             si_ready_o;
    logic             fault_i;
    logic [DI_W-1:0]  di_o;
    logic             di_valid_o;
    logic             di_ready_i;
    logic             flush_i;
    logic             halted_o;
    logic             busy_o;

    decode_sequencer #(.SI_W(SI_W), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .si_i       (si_i),
        .si_valid_i (si_valid_i),
        .si_ready_o (si_ready_o),
        .fault_i    (fault_i),
        .di_o       (di_o),
        .di_valid_o (di_valid_o),
        .di_ready_i (di_ready_i),
        .flush_i    (flush_i),
        .halted_o   (halted_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference state
    logic [ENT_W-1:0] q[$];
    logic [ID_W-1:0]  m_id;
    bit               m_halt;
    int               n_checks;
    int               n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Drive one cycle of inputs (at negedge), check outputs, advance model
    task automatic step(input logic v, input logic [SI_W-1:0] si, input logic f,
                        input logic dr, input logic fl);
        bit m_ready;
        bit m_push;
        bit m_pop;
        si_valid_i = v;
        si_i       = si;
        fault_i    = f;
        di_ready_i = dr;
        flush_i    = fl;
        #1;
        m_ready = (q.size() < 2) && !m_halt && !fl;
        check("si_ready", {31'b0, si_ready_o}, {31'b0, m_ready});
        check("di_valid", {31'b0, di_valid_o}, {31'b0, q.size() != 0});
        check("busy",     {31'b0, busy_o},     {31'b0, q.size() != 0});
        check("halted",   {31'b0, halted_o},   {31'b0, m_halt});
        if (q.size() != 0) check("di_o", {18'b0, di_o}, {18'b0, 1'b1, q[0]});
        else               check("di_o.valid", {31'b0, di_o[DI_W-1]}, 32'd0);
        m_push = v && m_ready;
        m_pop  = (q.size() != 0) && dr;
        if (fl) begin
            q.delete();
            m_halt = 1'b0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back({f, m_id, si});
                m_id = m_id + 4'd1;
                if (f && HALT_EN) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_id     = '0;
        m_halt   = 1'b0;
        // Reset with flush and a valid push asserted: reset must win
        rstn = 1'b0; si_valid_i = 1'b1; si_i = 8'hA5; fault_i = 1'b1;
        di_ready_i = 1'b1; flush_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Three pushes with downstream always ready, then idle
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: fill two, attempt a third, hold, then drain
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Flush at count=2 overrides push and pop in the same cycle
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Faulting push: halts (if enabled) and drains with fault=1
        step(1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Run the id counter through its wrap point
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional faults and flushes
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter: ID_W, default 20, width of the dynamic instruction id and of the id counter.
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: rstn  input  1  reset, synchronous, active-low.
REQ-004 Port: si_i  input  si_t  static instruction from fetch/predecode.
REQ-005 Port: si_valid_i  input  1  si_i valid.
REQ-006 Port: si_ready_o  output  1  sequencer accepts si_i this cycle.
REQ-007 Port: fault_i  input  1  combinational privilege/FPU fault verdict for the current si_i.
REQ-008 Port: di_o  output  di_t  dynamic instruction: si, id, fault, valid fields.
REQ-009 Port: di_valid_o  output  1  di_o holds a valid instruction.
REQ-010 Port: di_ready_i  input  1  downstream (rename/issue) accepts di_o.
REQ-011 Port: flush_i  input  1  pipeline flush from commit/trap logic.
REQ-012 Port: halted_o  output  1  sequencer in HALT state.
REQ-013 Port: busy_o  output  1  buffer non-empty.

Function
REQ-014 The block SHALL hold a 2-entry FIFO; each entry stores si, fault and id.
REQ-015 Push SHALL occur when si_valid_i && si_ready_o; the entry id SHALL be the current counter value, and the counter SHALL increment by 1, wrapping from 2^ID_W-1 to 0.
REQ-016 si_ready_o SHALL be (count<2) && state==RUN && !flush_i; it SHALL have no combinational dependence on di_ready_i.
REQ-017 di_valid_o SHALL be (count!=0); di_o SHALL present the head entry with di_o.valid equal to di_valid_o.
REQ-018 Pop SHALL occur when di_valid_o && di_ready_i; an entry is visible on di_o one cycle after push (latency 1).
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-020 di_o SHALL remain stable while di_valid_o && !di_ready_i.
REQ-021 States: RUN, HALT; RUN->HALT on push of an entry with fault_i=1 (when halting enabled, see REQ-028); HALT->RUN only on flush_i.
REQ-022 In HALT, pops SHALL continue, so that the faulting instruction drains to commit.
REQ-023 flush_i SHALL empty the FIFO at the next edge and SHALL override any push and pop in that cycle; the state SHALL go to RUN.
REQ-024 flush_i SHALL NOT reset the id counter; ids continue monotonically.
REQ-025 halted_o = (state==HALT); busy_o = (count!=0).

Reset
REQ-026 With rstn=0 at a rising edge: FIFO empty, count=0, id counter=0, state=RUN.
REQ-027 After reset: di_valid_o=0, di_o.valid=0, si_ready_o=1, halted_o=0, busy_o=0. Reset overrides flush_i and any handshake.

Configuration
REQ-028 Macro DECSEQ_HALT_ON_FAULT_EN: when defined, a faulting push enters HALT per REQ-021. When undefined, the HALT state is never entered, halted_o is tied to 0, and faulting instructions only carry fault=1 downstream.

Verification
REQ-029 Reset, then push 3 instructions with di_ready_i=1 -> ids 0,1,2 each appear on di_o one cycle after push; di_valid_o drops after the last.
REQ-030 di_ready_i=0, push 2 -> si_ready_o=0 at count=2; di_o holds id 0; after ready=1, order is id 0 then id 1, with no loss.
REQ-031 Preload counter near wrap (push 2^ID_W-1 instructions) -> the next ids are 2^ID_W-1 then 0.
REQ-032 (macro defined) Push id 5 with fault_i=1 -> halted_o=1, si_ready_o=0, id 5 drains with fault=1; flush_i -> RUN, and the next push gets id 6.
REQ-033 count=2, flush_i asserted with si_valid_i=1 and di_ready_i=1 in the same cycle -> next cycle count=0, no push, counter unchanged.
REQ-034 (macro undefined) Push with fault_i=1 -> halted_o stays 0, si_ready_o stays 1, di_o.fault=1.
